// File: rtl/debug_pkg.sv
// Shared encodings for the debug sequencer: host opcodes, sequencer FSM states,
// and the CPU control-state value that marks an instruction fetch.
package debug_pkg;

  typedef enum logic [2:0] {
    OP_RD_MEM = 3'd0,
    OP_WR_MEM = 3'd1,
    OP_RD_REG = 3'd2,
    OP_WR_REG = 3'd3,
    OP_RUN    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRHOLD,
    ST_RUN_RST,
    ST_RUN_EXEC,
    ST_RESP
  } seq_state_e;

  localparam logic [8:0] FETCH_STATE = 9'd1;

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_RD_MEM) || (op == OP_WR_MEM);
  endfunction

  function automatic logic is_reg_op(input logic [2:0] op);
    return (op == OP_RD_REG) || (op == OP_WR_REG);
  endfunction

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_WR_MEM) || (op == OP_WR_REG);
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
    return is_mem_op(op) || is_reg_op(op) || (op == OP_RUN);
  endfunction

endpackage

// File: rtl/debug_sequencer_fetch_counter.sv
// Counts rising entries into the CPU fetch state while enabled and flags the
// entry that completes N executed instructions (the (N+1)th fetch).
module fetch_counter
  import debug_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [8:0]       cpu_state_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             done_o
);

  logic [8:0]   prev_q;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic         entry;

  // prev_q is forced to a non-fetch value while idle so a CPU that comes out
  // of reset already in fetch still counts as one entry.
  assign entry  = enable_i && (cpu_state_i == FETCH_STATE) && (prev_q != FETCH_STATE);
  assign done_o = entry && (cnt_q == {1'b0, target_i});

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (entry && !done_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= enable_i ? cpu_state_i : '0;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_sequencer.sv
// Host-side test-port master for the 16-bit CPU: runs one memory/register
// access or bounded RUN per command and returns a single response.
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned ACC_WAIT    = 2,
  parameter int unsigned RUN_TIMEOUT = 65535,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        cpu_reset,
  output logic        test,
  output logic        memoryoperation,
  output logic        memorywrite,
  output logic        registeroperation,
  output logic        registerwrite,
  output logic [15:0] memaddress,
  output logic [15:0] memwritedata,
  output logic [15:0] regwritedata,
  output logic [15:0] resetpc,
  output logic [3:0]  registeraddress,
  input  logic [15:0] MD,
  input  logic [15:0] RD,
  input  logic [15:0] PC,
  input  logic [8:0]  state
);

  seq_state_e  state_q, state_d;
  logic [2:0]  op_q, op_n;
  logic [15:0] addr_q, addr_n, data_q, data_n;
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic        accept, acc_last, run_done, run_timeout;

  logic        rsp_err_d, cmd_ready_d, rsp_valid_d, cpu_reset_d, test_d;
  logic        memoryoperation_d, memorywrite_d, registeroperation_d, registerwrite_d;
  logic [15:0] rsp_data_d, memaddress_d, memwritedata_d, regwritedata_d, resetpc_d;
  logic [3:0]  registeraddress_d;

  assign accept      = (state_q == ST_IDLE) && cmd_valid;
  assign op_n        = accept ? cmd_op   : op_q;
  assign addr_n      = accept ? cmd_addr : addr_q;
  assign data_n      = accept ? cmd_data : data_q;
  assign acc_last    = (state_q == ST_ACCESS) && (acc_cnt_q == 16'(ACC_WAIT - 1));
  assign run_timeout = (state_q == ST_RUN_EXEC) && (cyc_q == 32'(RUN_TIMEOUT - 1));

  fetch_counter #(.CNT_W(CNT_W)) u_fetch_counter (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (state_q == ST_RUN_EXEC),
    .cpu_state_i (state),
    .target_i    (CNT_W'(data_q)),
    .done_o      (run_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_mem_op(cmd_op) || is_reg_op(cmd_op)) state_d = ST_ACCESS;
          else if (cmd_op == OP_RUN)                  state_d = ST_RUN_RST;
          else                                        state_d = ST_RESP;
        end
      end
      ST_ACCESS:   if (acc_last) state_d = is_write_op(op_q) ? ST_WRHOLD : ST_RESP;
      ST_WRHOLD:   state_d = ST_RESP;
      ST_RUN_RST:  state_d = ST_RUN_EXEC;
      ST_RUN_EXEC: if (run_done || run_timeout) state_d = ST_RESP;
      ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_cnt_d  = '0;
    cyc_d      = '0;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    if ((state_q == ST_ACCESS) && !acc_last) acc_cnt_d = acc_cnt_q + 16'd1;
    if ((state_q == ST_RUN_EXEC) && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;
    if (accept) begin
      rsp_data_d = '0;
      rsp_err_d  = !is_legal_op(cmd_op);
    end else if (acc_last) begin
      rsp_data_d = is_mem_op(op_q) ? MD : RD;
    end else if (state_q == ST_WRHOLD) begin
      rsp_err_d = (rsp_data != data_q);
    end else if ((state_q == ST_RUN_EXEC) && (run_done || run_timeout)) begin
      rsp_data_d = PC;
      rsp_err_d  = !run_done;
    end
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    cmd_ready_d         = 1'b0;
    rsp_valid_d         = 1'b0;
    cpu_reset_d         = 1'b0;
    test_d              = 1'b0;
    memoryoperation_d   = 1'b0;
    memorywrite_d       = 1'b0;
    registeroperation_d = 1'b0;
    registerwrite_d     = 1'b0;
    memaddress_d        = '0;
    memwritedata_d      = '0;
    regwritedata_d      = '0;
    resetpc_d           = '0;
    registeraddress_d   = '0;
    unique case (state_d)
      ST_IDLE: cmd_ready_d = 1'b1;
      ST_ACCESS, ST_WRHOLD: begin
        if (is_mem_op(op_n)) begin
          memoryoperation_d = 1'b1;
          memaddress_d      = addr_n;
        end else begin
          registeroperation_d = 1'b1;
          registeraddress_d   = addr_n[3:0];
        end
        if (state_d == ST_ACCESS) begin
          if (op_n == OP_WR_MEM) begin
            memorywrite_d  = 1'b1;
            memwritedata_d = data_n;
          end
          if (op_n == OP_WR_REG) begin
            registerwrite_d = 1'b1;
            regwritedata_d  = data_n;
          end
        end
      end
      ST_RUN_RST: begin
        cpu_reset_d = 1'b1;
        resetpc_d   = addr_n;
      end
      ST_RUN_EXEC: test_d      = 1'b1;
      ST_RESP:     rsp_valid_d = 1'b1;
      default:     cmd_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      op_q              <= '0;
      addr_q            <= '0;
      data_q            <= '0;
      acc_cnt_q         <= '0;
      cyc_q             <= '0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      cmd_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      cpu_reset         <= 1'b0;
      test              <= 1'b0;
      memoryoperation   <= 1'b0;
      memorywrite       <= 1'b0;
      registeroperation <= 1'b0;
      registerwrite     <= 1'b0;
      memaddress        <= '0;
      memwritedata      <= '0;
      regwritedata      <= '0;
      resetpc           <= '0;
      registeraddress   <= '0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_n;
      addr_q            <= addr_n;
      data_q            <= data_n;
      acc_cnt_q         <= acc_cnt_d;
      cyc_q             <= cyc_d;
      rsp_data          <= rsp_data_d;
      rsp_err           <= rsp_err_d;
      cmd_ready         <= cmd_ready_d;
      rsp_valid         <= rsp_valid_d;
      cpu_reset         <= cpu_reset_d;
      test              <= test_d;
      memoryoperation   <= memoryoperation_d;
      memorywrite       <= memorywrite_d;
      registeroperation <= registeroperation_d;
      registerwrite     <= registerwrite_d;
      memaddress        <= memaddress_d;
      memwritedata      <= memwritedata_d;
      regwritedata      <= regwritedata_d;
      resetpc           <= resetpc_d;
      registeraddress   <= registeraddress_d;
    end
  end

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer with a small behavioural CPU test-port
// model: 3-cycle instructions (fetch=1 -> 2 -> 4), PC advancing after fetch.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0, cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_data;
  logic        cpu_reset, test, memoryoperation, memorywrite, registeroperation, registerwrite;
  logic [15:0] memaddress, memwritedata, regwritedata, resetpc;
  logic [3:0]  registeraddress;
  logic [15:0] MD, RD, PC;
  logic [8:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_sequencer #(.ACC_WAIT(2), .RUN_TIMEOUT(20), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cpu_reset(cpu_reset), .test(test),
    .memoryoperation(memoryoperation), .memorywrite(memorywrite),
    .registeroperation(registeroperation), .registerwrite(registerwrite),
    .memaddress(memaddress), .memwritedata(memwritedata), .regwritedata(regwritedata),
    .resetpc(resetpc), .registeraddress(registeraddress),
    .MD(MD), .RD(RD), .PC(PC), .state(state)
  );

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:15];
  logic [15:0] cpu_pc = '0;
  logic [8:0]  cpu_st = '0;
  logic        stall = 1'b0, wr_block = 1'b0;

  assign MD    = mem[memaddress];
  assign RD    = regs[registeraddress];
  assign PC    = cpu_pc;
  assign state = cpu_st;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
  end

  always @(posedge clk) begin
    if (memoryoperation && memorywrite && !wr_block) mem[memaddress] <= memwritedata;
    if (registeroperation && registerwrite && !wr_block) regs[registeraddress] <= regwritedata;
    if (cpu_reset) begin
      cpu_pc <= resetpc;
      cpu_st <= 9'd0;
    end else if (test) begin
      if (stall) cpu_st <= 9'd8;
      else case (cpu_st)
        9'd1: begin cpu_st <= 9'd2; cpu_pc <= cpu_pc + 16'd1; end
        9'd2: cpu_st <= 9'd4;
        default: cpu_st <= 9'd1;
      endcase
    end
  end

  // Issue one command, wait (bounded) for the response, consume it.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic re, output int lat, output bit to);
    int w;
    to = 1'b0; rd = '0; re = 1'b0; lat = 0; w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (!cmd_ready) to = 1'b1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) to = 1'b1;
    rd = rsp_data; re = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({test, cpu_reset, memoryoperation, memorywrite, registeroperation, registerwrite} !== 6'b0)
      begin errors++; $display("FAIL reset_strobes: got %b expected 000000",
        {test, cpu_reset, memoryoperation, memorywrite, registeroperation, registerwrite}); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
  endtask

  task automatic test_mem_rw();
    logic [15:0] rd; logic re; int lat; bit to;
    do_cmd(3'd1, 16'd3, 16'h4007, rd, re, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrmem_timeout: got %b expected 0", to); end
    checks++; if (rd !== 16'h4007) begin errors++; $display("FAIL wrmem_data: got %h expected 4007", rd); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL wrmem_err: got %b expected 0", re); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wrmem_latency: got %0d expected 3", lat); end
    do_cmd(3'd0, 16'd3, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h4007) begin errors++; $display("FAIL rdmem_data: got %h expected 4007", rd); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL rdmem_err: got %b expected 0", re); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rdmem_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_reg_rw();
    logic [15:0] rd; logic re; int lat; bit to;
    do_cmd(3'd3, 16'd5, 16'h1234, rd, re, lat, to);
    checks++; if (rd !== 16'h1234 || re !== 1'b0) begin errors++; $display("FAIL wrreg: got %h/%b expected 1234/0", rd, re); end
    do_cmd(3'd2, 16'd5, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h1234 || re !== 1'b0) begin errors++; $display("FAIL rdreg: got %h/%b expected 1234/0", rd, re); end
    do_cmd(3'd2, 16'd0, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rdreg_r0: got %h expected 0000", rd); end
  endtask

  task automatic test_write_strobes();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = 16'h0007; cmd_data = 16'hA5A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if ({registeroperation, registerwrite, memoryoperation, test, cmd_ready} !== 5'b11000)
        begin errors++; $display("FAIL wr_access_strobes: got %b expected 11000",
          {registeroperation, registerwrite, memoryoperation, test, cmd_ready}); end
      checks++; if (registeraddress !== 4'd7 || regwritedata !== 16'hA5A5)
        begin errors++; $display("FAIL wr_access_addr_data: got %h/%h expected 7/a5a5", registeraddress, regwritedata); end
      @(negedge clk);
    end
    checks++; if ({registeroperation, registerwrite, rsp_valid} !== 3'b100)
      begin errors++; $display("FAIL wrhold_strobes: got %b expected 100", {registeroperation, registerwrite, rsp_valid}); end
    @(negedge clk);
    checks++; if ({registeroperation, rsp_valid} !== 2'b01)
      begin errors++; $display("FAIL resp_strobes: got %b expected 01", {registeroperation, rsp_valid}); end
    checks++; if (rsp_data !== 16'hA5A5 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL wr_readback: got %h/%b expected a5a5/0", rsp_data, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01)
      begin errors++; $display("FAIL resp_release: got %b expected 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_wr_mismatch();
    logic [15:0] rd; logic re; int lat; bit to;
    wr_block = 1'b1;
    do_cmd(3'd1, 16'd9, 16'hBEEF, rd, re, lat, to);
    wr_block = 1'b0;
    checks++; if (rd !== 16'h0000 || re !== 1'b1) begin errors++; $display("FAIL wr_mismatch: got %h/%b expected 0000/1", rd, re); end
  endtask

  task automatic test_run();
    logic [15:0] rd; logic re; int lat; bit to;
    do_cmd(3'd4, 16'd3, 16'd0, rd, re, lat, to);
    checks++; if (rd !== 16'h0003 || re !== 1'b0) begin errors++; $display("FAIL run_n0: got %h/%b expected 0003/0", rd, re); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL run_n0_latency: got %0d expected 3", lat); end
    do_cmd(3'd4, 16'h0010, 16'd2, rd, re, lat, to);
    checks++; if (rd !== 16'h0012 || re !== 1'b0) begin errors++; $display("FAIL run_n2: got %h/%b expected 0012/0", rd, re); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL run_n2_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_run_phases();
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 16'h0020; cmd_data = 16'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({cpu_reset, test} !== 2'b10 || resetpc !== 16'h0020)
      begin errors++; $display("FAIL run_rst_phase: got %b/%h expected 10/0020", {cpu_reset, test}, resetpc); end
    @(negedge clk);
    checks++; if ({cpu_reset, test, memoryoperation, registeroperation} !== 4'b0100)
      begin errors++; $display("FAIL run_exec_phase: got %b expected 0100",
        {cpu_reset, test, memoryoperation, registeroperation}); end
    while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
    checks++; if (rsp_valid !== 1'b1 || test !== 1'b0)
      begin errors++; $display("FAIL run_end: got valid=%b test=%b expected 1/0", rsp_valid, test); end
    checks++; if (rsp_data !== 16'h0021 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL run_n1_pc: got %h/%b expected 0021/0", rsp_data, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int w = 0, tcnt = 0;
    stall = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 16'h0040; cmd_data = 16'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && w < 100) begin
      if (test) tcnt++;
      @(negedge clk); w++;
    end
    checks++; if (tcnt !== 20) begin errors++; $display("FAIL timeout_cycles: got %0d expected 20", tcnt); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0040 || test !== 1'b0)
      begin errors++; $display("FAIL timeout_rsp: got err=%b data=%h test=%b expected 1/0040/0", rsp_err, rsp_data, test); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_illegal_hold();
    logic [15:0] rd; logic re; int lat; bit to;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 16'hFFFF; cmd_data = 16'hFFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({rsp_valid, rsp_err, cmd_ready} !== 3'b110 || rsp_data !== 16'h0000)
        begin errors++; $display("FAIL illegal_hold%0d: got %b/%h expected 110/0000", c, {rsp_valid, rsp_err, cmd_ready}, rsp_data); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL illegal_release: got %b expected 01", {rsp_valid, cmd_ready}); end
    do_cmd(3'd5, 16'd1, 16'd1, rd, re, lat, to);
    checks++; if (rd !== 16'h0000 || re !== 1'b1 || lat !== 0)
      begin errors++; $display("FAIL illegal_op5: got %h/%b/%0d expected 0000/1/0", rd, re, lat); end
    do_cmd(3'd7, 16'd1, 16'd1, rd, re, lat, to);
    checks++; if (rd !== 16'h0000 || re !== 1'b1) begin errors++; $display("FAIL illegal_op7: got %h/%b expected 0000/1", rd, re); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic re; int lat; bit to;
    do_cmd(3'd1, 16'h0100, 16'h1111, rd, re, lat, to);
    do_cmd(3'd1, 16'h0101, 16'h2222, rd, re, lat, to);
    do_cmd(3'd0, 16'h0100, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL b2b_rd100: got %h expected 1111", rd); end
    do_cmd(3'd0, 16'h0101, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL b2b_rd101: got %h expected 2222", rd); end
    do_cmd(3'd4, 16'h0100, 16'd3, rd, re, lat, to);
    checks++; if (rd !== 16'h0103 || re !== 1'b0) begin errors++; $display("FAIL b2b_run: got %h/%b expected 0103/0", rd, re); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] rd; logic re; int lat; bit to;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 16'h0050; cmd_data = 16'd100;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({test, cpu_reset, memoryoperation, memorywrite, registeroperation, registerwrite, rsp_valid, cmd_ready} !== 8'b00000001)
      begin errors++; $display("FAIL reset_mid_run: got %b expected 00000001",
        {test, cpu_reset, memoryoperation, memorywrite, registeroperation, registerwrite, rsp_valid, cmd_ready}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_rsp: got %b expected 0", rsp_valid); end
    do_cmd(3'd0, 16'd3, 16'h0000, rd, re, lat, to);
    checks++; if (rd !== 16'h4007 || to !== 1'b0) begin errors++; $display("FAIL post_reset_rd: got %h/%b expected 4007/0", rd, to); end
  endtask

  initial begin
    test_reset();
    test_mem_rw();
    test_reg_rw();
    test_write_strobes();
    test_wr_mismatch();
    test_run();
    test_run_phases();
    test_timeout();
    test_illegal_hold();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Host-side controller for the multi-cycle 16-bit CPU's test port.
- Accepts one command at a time: memory read/write, register read/write, or run-N-instructions.
- Sequences the CPU's test/reset/memory/register control lines cycle by cycle and returns one response per command.
- Sits between a host (UART/bench driver) and the SystemTest top; it replaces hand-written bench tasks and is the only master of the test port.

Parameters:
- ACC_WAIT, 2, cycles a memory/register access is held before MD/RD is sampled
- RUN_TIMEOUT, 65535, max clk cycles in a RUN before aborting with error
- CNT_W, 16, width of instruction counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  sequencer idle, accepts command this cycle
- cmd_op  in  3  0=RD_MEM 1=WR_MEM 2=RD_REG 3=WR_REG 4=RUN; 5-7 illegal
- cmd_addr  in  16  mem address / reg address (bits 3:0) / start PC for RUN
- cmd_data  in  16  write data / instruction count N for RUN
- rsp_valid  out  1  response available
- rsp_ready  in  1  host consumes response
- rsp_data  out  16  read data, readback of write, or final PC for RUN
- rsp_err  out  1  write readback mismatch, RUN timeout, or illegal op
- cpu_reset  out  1  drives CPU reset
- test  out  1  CPU run enable
- memoryoperation, memorywrite, registeroperation, registerwrite  out  1 each  test-port strobes
- memaddress, memwritedata, regwritedata, resetpc  out  16 each
- registeraddress  out  4
- MD, RD, PC  in  16 each  CPU memory data, register data, program counter
- state  in  9  CPU control state; value 1 = fetch

Behaviour:
- Reset: FSM to IDLE. All outputs 0, except cmd_ready=1. Counters cleared.
- Reset mid-command aborts the command with no response. Strobes drop in the same cycle reset is sampled.
- States: IDLE, ACCESS, WRHOLD, RUN_RST, RUN_EXEC, RESP.
- Command handshake: the command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Op, addr and data are latched at acceptance.
- Illegal op: IDLE goes straight to RESP with rsp_err=1 and rsp_data=0.
- Memory/register ops, IDLE->ACCESS:
  - Assert the matching operation strobe and address; for writes also assert the write strobe and data. test=0.
  - Hold for ACC_WAIT cycles, then sample MD (mem) or RD (reg) into rsp_data.
  - Writes: deassert the write strobe and go to WRHOLD for 1 cycle, keeping the operation strobe. Then compare the readback with the written data; mismatch sets rsp_err.
  - Operation strobe drops on entering RESP.
- RUN:
  - IDLE->RUN_RST: cpu_reset=1, resetpc=cmd_addr, test=0 for 1 cycle.
  - Then RUN_EXEC: cpu_reset=0, test=1.
  - Fetch entry is counted when state==1 and the previous-cycle state!=1.
  - RUN completes at the (N+1)th fetch entry: N instructions executed, next fetch reached. test drops the same cycle. rsp_data=PC sampled that cycle.
  - N=0 completes at the first fetch entry.
  - Cycle counter reaching RUN_TIMEOUT: test=0, rsp_err=1, rsp_data=PC.
- RESP: rsp_valid=1, data and err stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE; rsp_valid drops next cycle.
- Outputs in a given state are registered, one cycle after the transition decision. All strobes are mutually exclusive with test=1.
- Counters saturate, never wrap. The fetch counter is CNT_W+1 bits so N=16'hFFFF is legal.

Decomposition:
- Shared package debug_pkg: cmd_op encodings (OP_RD_MEM..OP_RUN), FSM state enum, FETCH_STATE=9'd1.
- One natural sub-module: fetch_counter (edge-detects fetch, counts to N+1, asserts done).

Test Plan:
- WR_MEM addr=3 data=16'h4007, then RD_MEM addr=3 -> both rsp_data=16'h4007, rsp_err=0.
- WR_REG r0=11; WR_MEM 3=16'h4007; RUN addr=3 N=1; RD_REG r0 -> final rsp_data=0, RUN rsp_err=0.
- Mem 4..6 = 16'h5127, 16'hF002, 16'h0FFF; r1=r2=11; RUN addr=4 N=2 -> RUN rsp_data=16'h0FFF. With r1=10: rsp_data=16'h0007.
- RUN with the CPU held out of fetch (state forced !=1), RUN_TIMEOUT=20 -> rsp_err=1 after 20 cycles, test=0.
- cmd_op=6 -> immediate rsp_err=1, rsp_data=0. Holding rsp_ready=0 for 5 cycles keeps rsp_valid and rsp_data stable and cmd_ready=0.
- Reset asserted in the 3rd cycle of RUN_EXEC -> next cycle all strobes and test are 0, cmd_ready=1, no rsp_valid.
